// File: rtl/fwd_scoreboard.sv
// Operand forwarding select, load-use / multi-cycle hazard stall, and perf counters.
// Youngest matching in-flight producer wins; the mul/div unit is tracked by a down-counter.
module fwd_scoreboard #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned NUM_STG = 3,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned SEL_W  = $clog2(NUM_STG + 1)
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NUM_SRC*5-1:0]     i_src_addr,
  input  logic [NUM_SRC*2-1:0]     i_src_kind,
  input  logic [NUM_SRC-1:0]       i_src_used,
  input  logic [NUM_STG-1:0]       i_stg_we,
  input  logic [NUM_STG*5-1:0]     i_stg_waddr,
  input  logic [NUM_STG-1:0]       i_stg_wlo,
  input  logic [NUM_STG-1:0]       i_stg_whi,
  input  logic [NUM_STG-1:0]       i_stg_load,
  input  logic                     i_id_advance,
  input  logic                     i_md_start,
  input  logic [5:0]               i_md_cycles,
  output logic [NUM_SRC*SEL_W-1:0] o_fwd_sel,
  output logic                     o_stall,
  output logic                     o_md_busy,
  output logic [CNT_W-1:0]         o_stall_cnt,
  output logic [CNT_W-1:0]         o_fwd_cnt
);

  localparam logic [1:0] KindGpr = 2'b00;
  localparam logic [1:0] KindLo  = 2'b01;
  localparam logic [1:0] KindHi  = 2'b10;

  logic [5:0]               r_md_cnt;
  logic [CNT_W-1:0]         r_stall_cnt;
  logic [CNT_W-1:0]         r_fwd_cnt;

  logic [NUM_STG-1:0]       w_match [NUM_SRC];
  logic [NUM_SRC-1:0]       w_src_ld;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic                     w_load_use;
  logic                     w_lohi_used;
  logic                     w_fwd_used;
  logic                     w_md_busy;
  logic                     w_md_hazard;
  logic                     w_stall;
  logic                     w_md_accept;
  logic [5:0]               w_md_len;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < NUM_STG; k++) begin
        unique case (i_src_kind[2*i +: 2])
          KindGpr: w_match[i][k] = i_stg_we[k] && (i_src_addr[5*i +: 5] != 5'd0) &&
                                   (i_stg_waddr[5*k +: 5] == i_src_addr[5*i +: 5]);
          KindLo:  w_match[i][k] = i_stg_wlo[k];
          KindHi:  w_match[i][k] = i_stg_whi[k];
          default: w_match[i][k] = 1'b0;
        endcase
      end
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    w_fwd_sel   = '0;
    w_src_ld    = '0;
    w_load_use  = 1'b0;
    w_lohi_used = 1'b0;
    w_fwd_used  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_STG - 1; k >= 0; k--) begin
        if (w_match[i][k]) begin
          w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          w_src_ld[i]                 = i_stg_load[k];
        end
      end
      w_load_use  = w_load_use | (i_src_used[i] & w_src_ld[i]);
      w_fwd_used  = w_fwd_used | (i_src_used[i] & (|w_match[i]));
      w_lohi_used = w_lohi_used | (i_src_used[i] &
                    ((i_src_kind[2*i +: 2] == KindLo) | (i_src_kind[2*i +: 2] == KindHi)));
    end
  end

  always_comb begin
    w_md_busy   = (r_md_cnt != 6'd0);
    w_md_hazard = w_md_busy & (i_md_start | w_lohi_used);
    w_stall     = w_load_use | w_md_hazard;
    w_md_accept = i_md_start & ~w_md_busy & ~w_stall;
    w_md_len    = (i_md_cycles == 6'd0) ? 6'd1 : i_md_cycles;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_md_accept) begin
        r_md_cnt <= w_md_len;
      end else if (w_md_busy) begin
        r_md_cnt <= r_md_cnt - 6'd1;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (i_id_advance && !w_stall && w_fwd_used && (r_fwd_cnt != '1)) begin
        r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
      end
    end
  end

  assign o_fwd_sel   = w_fwd_sel;
  assign o_stall     = w_stall;
  assign o_md_busy   = w_md_busy;
  assign o_stall_cnt = r_stall_cnt;
  assign o_fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: forwarding priority, load-use, mul/div busy, reset, saturation.
// A second instance with 4-bit counters shares all inputs to exercise saturation.
module tb_fwd_scoreboard;

  localparam int NSRC = 4;
  localparam int NSTG = 3;
  localparam int SELW = 2;
  localparam logic [1:0] K_GPR  = 2'b00;
  localparam logic [1:0] K_LO   = 2'b01;
  localparam logic [1:0] K_HI   = 2'b10;
  localparam logic [1:0] K_NONE = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSRC*5-1:0]    src_addr;
  logic [NSRC*2-1:0]    src_kind;
  logic [NSRC-1:0]      src_used;
  logic [NSTG-1:0]      stg_we, stg_wlo, stg_whi, stg_load;
  logic [NSTG*5-1:0]    stg_waddr;
  logic                 id_advance, md_start;
  logic [5:0]           md_cycles;
  logic [NSRC*SELW-1:0] fwd_sel, s_fwd_sel;
  logic                 stall, md_busy, s_stall, s_md_busy;
  logic [31:0]          stall_cnt, fwd_cnt;
  logic [3:0]           s_stall_cnt, s_fwd_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .i_clock(clk), .i_reset(rst), .i_src_addr(src_addr), .i_src_kind(src_kind),
    .i_src_used(src_used), .i_stg_we(stg_we), .i_stg_waddr(stg_waddr), .i_stg_wlo(stg_wlo),
    .i_stg_whi(stg_whi), .i_stg_load(stg_load), .i_id_advance(id_advance),
    .i_md_start(md_start), .i_md_cycles(md_cycles), .o_fwd_sel(fwd_sel), .o_stall(stall),
    .o_md_busy(md_busy), .o_stall_cnt(stall_cnt), .o_fwd_cnt(fwd_cnt)
  );

  fwd_scoreboard #(.CNT_W(4)) dut_small (
    .i_clock(clk), .i_reset(rst), .i_src_addr(src_addr), .i_src_kind(src_kind),
    .i_src_used(src_used), .i_stg_we(stg_we), .i_stg_waddr(stg_waddr), .i_stg_wlo(stg_wlo),
    .i_stg_whi(stg_whi), .i_stg_load(stg_load), .i_id_advance(id_advance),
    .i_md_start(md_start), .i_md_cycles(md_cycles), .o_fwd_sel(s_fwd_sel), .o_stall(s_stall),
    .o_md_busy(s_md_busy), .o_stall_cnt(s_stall_cnt), .o_fwd_cnt(s_fwd_cnt)
  );

  function automatic logic [SELW-1:0] sel(input int i);
    return fwd_sel[i*SELW +: SELW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_addr = '0; src_kind = '1; src_used = '0;
    stg_we = '0; stg_waddr = '0; stg_wlo = '0; stg_whi = '0; stg_load = '0;
    id_advance = 1'b0; md_start = 1'b0; md_cycles = 6'd0;
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic [1:0] k, input logic u);
    src_addr[5*i +: 5] = a;
    src_kind[2*i +: 2] = k;
    src_used[i]        = u;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (md_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", md_busy); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else passed++;
    checks++; if (stall_cnt !== 32'd0) $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); else passed++;
    checks++; if (fwd_cnt !== 32'd0) $display("FAIL rst_fwd_cnt: got %0d want 0", fwd_cnt); else passed++;
    checks++; if (fwd_sel !== '0) $display("FAIL rst_fwd_sel: got %h want 0", fwd_sel); else passed++;
  endtask

  task automatic test_fwd_priority();
    do_reset();
    set_src(0, 5'd8, K_GPR, 1'b1);
    stg_we = 3'b111; stg_waddr = {5'd8, 5'd8, 5'd8};
    #1;
    checks++; if (sel(0) !== 2'd1) $display("FAIL fwd_youngest: got %0d want 1", sel(0)); else passed++;
    stg_we = 3'b110; #1;
    checks++; if (sel(0) !== 2'd2) $display("FAIL fwd_stage1: got %0d want 2", sel(0)); else passed++;
    stg_we = 3'b100; #1;
    checks++; if (sel(0) !== 2'd3) $display("FAIL fwd_stage2: got %0d want 3", sel(0)); else passed++;
    stg_we = 3'b111; stg_waddr = {5'd0, 5'd0, 5'd0}; set_src(0, 5'd0, K_GPR, 1'b1); #1;
    checks++; if (sel(0) !== 2'd0) $display("FAIL fwd_r0: got %0d want 0", sel(0)); else passed++;
    stg_waddr = {5'd9, 5'd9, 5'd7}; set_src(0, 5'd9, K_GPR, 1'b0); #1;
    checks++; if (sel(0) !== 2'd2) $display("FAIL fwd_unused: got %0d want 2", sel(0)); else passed++;
    set_src(2, 5'd9, K_LO, 1'b1); stg_wlo = 3'b110; #1;
    checks++; if (sel(2) !== 2'd2) $display("FAIL fwd_lo: got %0d want 2", sel(2)); else passed++;
    set_src(3, 5'd9, K_HI, 1'b1); stg_whi = 3'b100; #1;
    checks++; if (sel(3) !== 2'd3) $display("FAIL fwd_hi: got %0d want 3", sel(3)); else passed++;
    set_src(1, 5'd9, K_NONE, 1'b1); stg_wlo = 3'b111; stg_whi = 3'b111; #1;
    checks++; if (sel(1) !== 2'd0) $display("FAIL fwd_none: got %0d want 0", sel(1)); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_src(1, 5'd5, K_GPR, 1'b1);
    stg_we = 3'b001; stg_waddr = {5'd0, 5'd0, 5'd5}; stg_load = 3'b001; id_advance = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else passed++;
    tick(); tick(); tick();
    checks++; if (stall_cnt !== 32'd3) $display("FAIL lu_stall_cnt: got %0d want 3", stall_cnt); else passed++;
    checks++; if (fwd_cnt !== 32'd0) $display("FAIL lu_fwd_cnt_stalled: got %0d want 0", fwd_cnt); else passed++;
    stg_load = 3'b000; #1;
    checks++; if (stall !== 1'b0) $display("FAIL lu_clear: got %b want 0", stall); else passed++;
    checks++; if (sel(1) !== 2'd1) $display("FAIL lu_sel: got %0d want 1", sel(1)); else passed++;
    tick();
    checks++; if (fwd_cnt !== 32'd1) $display("FAIL lu_fwd_cnt: got %0d want 1", fwd_cnt); else passed++;
    checks++; if (stall_cnt !== 32'd3) $display("FAIL lu_stall_hold: got %0d want 3", stall_cnt); else passed++;
    id_advance = 1'b0; tick();
    id_advance = 1'b1; src_used = '0; tick();
    checks++; if (fwd_cnt !== 32'd1) $display("FAIL lu_fwd_gate: got %0d want 1", fwd_cnt); else passed++;
    stg_load = 3'b001; #1;
    checks++; if (stall !== 1'b0) $display("FAIL lu_unused_load: got %b want 0", stall); else passed++;
  endtask

  task automatic test_md();
    do_reset();
    md_start = 1'b1; md_cycles = 6'd4; #1;
    checks++; if (stall !== 1'b0) $display("FAIL md_pre_stall: got %b want 0", stall); else passed++;
    tick();
    md_start = 1'b0; set_src(0, 5'd0, K_LO, 1'b1); #1;
    checks++; if (md_busy !== 1'b1) $display("FAIL md_busy1: got %b want 1", md_busy); else passed++;
    checks++; if (stall !== 1'b1) $display("FAIL md_lo_stall: got %b want 1", stall); else passed++;
    for (int n = 2; n <= 4; n++) begin
      tick();
      checks++; if (md_busy !== 1'b1) $display("FAIL md_busy%0d: got %b want 1", n, md_busy); else passed++;
    end
    tick();
    checks++; if (md_busy !== 1'b0) $display("FAIL md_done: got %b want 0", md_busy); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL md_done_stall: got %b want 0", stall); else passed++;
    checks++; if (stall_cnt !== 32'd4) $display("FAIL md_stall_cnt: got %0d want 4", stall_cnt); else passed++;
  endtask

  task automatic test_md_zero();
    do_reset();
    md_start = 1'b1; md_cycles = 6'd0;
    tick();
    md_cycles = 6'd2; #1;
    checks++; if (md_busy !== 1'b1) $display("FAIL mz_busy: got %b want 1", md_busy); else passed++;
    checks++; if (stall !== 1'b1) $display("FAIL mz_held_stall: got %b want 1", stall); else passed++;
    tick();
    checks++; if (md_busy !== 1'b0) $display("FAIL mz_one_cycle: got %b want 0", md_busy); else passed++;
    checks++; if (stall_cnt !== 32'd1) $display("FAIL mz_stall_cnt: got %0d want 1", stall_cnt); else passed++;
    tick();
    md_start = 1'b0; #1;
    checks++; if (md_busy !== 1'b1) $display("FAIL mz_second_accept: got %b want 1", md_busy); else passed++;
    tick();
    checks++; if (md_busy !== 1'b1) $display("FAIL mz_second_busy: got %b want 1", md_busy); else passed++;
    tick();
    checks++; if (md_busy !== 1'b0) $display("FAIL mz_second_done: got %b want 0", md_busy); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    md_start = 1'b1; md_cycles = 6'd5;
    tick();
    md_start = 1'b0; set_src(0, 5'd0, K_HI, 1'b1);
    tick(); tick();
    checks++; if (stall_cnt !== 32'd2) $display("FAIL rm_pre_cnt: got %0d want 2", stall_cnt); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++; if (md_busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", md_busy); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL rm_stall: got %b want 0", stall); else passed++;
    checks++; if (stall_cnt !== 32'd0) $display("FAIL rm_stall_cnt: got %0d want 0", stall_cnt); else passed++;
    checks++; if (fwd_cnt !== 32'd0) $display("FAIL rm_fwd_cnt: got %0d want 0", fwd_cnt); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    set_src(1, 5'd5, K_GPR, 1'b1);
    stg_we = 3'b001; stg_waddr = {5'd0, 5'd0, 5'd5}; stg_load = 3'b001;
    for (int n = 0; n < 15; n++) tick();
    checks++; if (s_stall_cnt !== 4'd15) $display("FAIL sat_reach: got %0d want 15", s_stall_cnt); else passed++;
    for (int n = 0; n < 5; n++) tick();
    checks++; if (s_stall_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", s_stall_cnt); else passed++;
    checks++; if (stall_cnt !== 32'd20) $display("FAIL sat_wide: got %0d want 20", stall_cnt); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_md();
    test_md_zero();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 4, number of source operands checked per cycle (branch-in-ID and EX operands alike).
REQ-002 Parameter NUM_STG, default 3, number of in-flight producer stages; index 0 = youngest (ID/EX), NUM_STG-1 = oldest (MEM/WB).
REQ-003 Parameter CNT_W, default 32, width of event counters; derived SEL_W = clog2(NUM_STG+1).
REQ-004 One clock; reset is synchronous and active-high. Ports: clock  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-005 src_addr  in  NUM_SRC*5  GPR index per source, source i at bits [5i+4:5i].
REQ-006 src_kind  in  NUM_SRC*2  per source: 00 GPR, 01 LO, 10 HI, 11 none.
REQ-007 src_used  in  NUM_SRC  source i is actually read this cycle.
REQ-008 stg_we  in  NUM_STG  stage k writes a GPR.
REQ-009 stg_waddr  in  NUM_STG*5  GPR destination of stage k.
REQ-010 stg_wlo / stg_whi  in  NUM_STG each  stage k writes LO / HI.
REQ-011 stg_load  in  NUM_STG  stage k result not yet available (load in flight).
REQ-012 id_advance  in  1  ID instruction leaves ID this cycle if not stalled.
REQ-013 md_start  in  1  request to start a multi-cycle multiply/divide.
REQ-014 md_cycles  in  6  latency of the requested operation.
REQ-015 fwd_sel  out  NUM_SRC*SEL_W  per source: 0 register file, k+1 forward from stage k.
REQ-016 stall  out  1  hold ID and earlier stages.
REQ-017 md_busy  out  1  multi-cycle unit occupied.
REQ-018 stall_cnt / fwd_cnt  out  CNT_W each  performance counters.

Function
REQ-019 GPR match(i,k): src_kind[i]=00 & stg_we[k] & stg_waddr[k]==src_addr[i] & src_addr[i]!=0.
REQ-020 LO match(i,k): src_kind[i]=01 & stg_wlo[k]; HI match(i,k): src_kind[i]=10 & stg_whi[k]; kind 11 never matches.
REQ-021 fwd_sel[i] = k+1 for smallest matching k (youngest wins); 0 if none; combinational, independent of src_used.
REQ-022 Load-use hazard: any i with src_used[i] whose selected stage k has stg_load[k]=1.
REQ-023 md_hazard: md_busy & (md_start | any i with src_used[i] & src_kind[i] in {01,10}).
REQ-024 stall = load-use hazard | md_hazard; combinational from inputs and registered md state only.
REQ-025 md_start accepted when md_busy=0 and stall=0; counter loads max(md_cycles,1); otherwise ignored, requester must hold it.
REQ-026 Counter decrements by 1 each cycle when nonzero; md_busy = (counter!=0), registered state.
REQ-027 Latency: start accepted at edge t -> md_busy=1 for exactly N cycles after t, 0 thereafter.
REQ-028 stall_cnt +1 every cycle stall=1; saturates at all-ones, no wrap.
REQ-029 fwd_cnt +1 on cycles with id_advance=1, stall=0 and any fwd_sel[i]!=0 with src_used[i]; saturates, no wrap.
REQ-030 Simultaneous md countdown reaching 0 and md_start: start refused that cycle (busy still 1), accepted next cycle.

Reset
REQ-031 On reset: md counter 0, md_busy 0, stall_cnt 0, fwd_cnt 0; fwd_sel/stall then follow inputs combinationally.
REQ-032 Reset mid-operation aborts operation: md_busy 0 next cycle, no residual stall.

Verification
REQ-033 src0 GPR 8 used; stg_we=111, waddr 8/8/8 -> fwd_sel[0]=1; stg_we=110 -> 2; addr 0 -> 0 regardless.
REQ-034 src1 GPR 5 used; stage0 writes 5 with stg_load[0]=1 -> stall=1, stall_cnt +1 per cycle; clear load -> stall=0, fwd_sel[1]=1.
REQ-035 md_start, md_cycles=4, no hazard -> md_busy high 4 cycles; LO read during busy -> stall=1; after busy drops -> stall=0.
REQ-036 md_cycles=0 -> busy exactly 1 cycle; md_start held during busy -> accepted only after busy=0.
REQ-037 Assert reset during busy with counter=3 -> md_busy=0, stall=0, both counters 0 next cycle.
REQ-038 Preload stall_cnt near all-ones (CNT_W=4), hold stall -> stays 15, no wrap.
